// File: rtl/frontend_stall_ctrl_pkg.sv
// Shared constants for the pipeline front end: FSM encodings, reset/flush
// defaults and the sequential PC step.
package frontend_stall_ctrl_pkg;

    typedef logic [1:0] fe_state_t;

    localparam fe_state_t FE_RUN   = 2'd0;
    localparam fe_state_t FE_STALL = 2'd1;
    localparam fe_state_t FE_FLUSH = 2'd2;

    localparam int          FE_CTRL_W    = 8;
    localparam int          FE_PC_INC    = 4;
    localparam logic [31:0] FE_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/frontend_stall_ctrl_if.sv
// Bundle of hazard/branch/fetch/decode inputs and the front-end state outputs.
// The slave side is the front end itself; the master side is the surrounding pipeline.
interface frontend_stall_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 8,
    parameter int CNT_W   = 16
);
    logic               HD_HoldPC;
    logic               HD_Hold_IF_ID;
    logic               HD_HoldControl;
    logic               EX_BranchTaken;
    logic [ADDR_W-1:0]  EX_BranchTarget;
    logic [INSTR_W-1:0] IMem_Instr;
    logic [CTRL_W-1:0]  ID_Ctrl;

    logic [ADDR_W-1:0]  PC;
    logic [ADDR_W-1:0]  IF_ID_PC;
    logic [INSTR_W-1:0] IF_ID_Instr;
    logic               IF_ID_Valid;
    logic [CTRL_W-1:0]  ID_EX_Ctrl;
    logic               ID_EX_Valid;
    logic [1:0]         FE_State;
    logic [CNT_W-1:0]   StallCount;
    logic [CNT_W-1:0]   FlushCount;
    logic               HoldMismatch;
    logic               StallTimeout;

    modport master (
        output HD_HoldPC, HD_Hold_IF_ID, HD_HoldControl,
        output EX_BranchTaken, EX_BranchTarget, IMem_Instr, ID_Ctrl,
        input  PC, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, ID_EX_Ctrl, ID_EX_Valid,
        input  FE_State, StallCount, FlushCount, HoldMismatch, StallTimeout
    );

    modport slave (
        input  HD_HoldPC, HD_Hold_IF_ID, HD_HoldControl,
        input  EX_BranchTaken, EX_BranchTarget, IMem_Instr, ID_Ctrl,
        output PC, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, ID_EX_Ctrl, ID_EX_Valid,
        output FE_State, StallCount, FlushCount, HoldMismatch, StallTimeout
    );
endinterface

// File: rtl/frontend_stall_ctrl_sat_counter.sv
// Statistics counter that increments on enable and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/frontend_stall_ctrl.sv
// Pipeline front end: owns PC, IF/ID and the control half of ID/EX, and applies
// branch flush, hold and bubble actions with branch taking priority over holds.
module frontend_stall_ctrl
    import frontend_stall_ctrl_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 CTRL_W    = FE_CTRL_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FE_NOP_INSTR),
    parameter int                 MAX_STALL = 8,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    frontend_stall_ctrl_if.slave fe
);
    localparam int SR_W = $clog2(MAX_STALL + 1);

    logic [ADDR_W-1:0]  pc_q,        pc_d;
    logic [ADDR_W-1:0]  if_id_pc_q,  if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [CTRL_W-1:0]  id_ex_ctrl_q, id_ex_ctrl_d;
    logic               id_ex_valid_q, id_ex_valid_d;
    fe_state_t          state_q,     state_d;
    logic [SR_W-1:0]    stall_run_q, stall_run_d;
    logic               mismatch_q,  mismatch_d;
    logic               timeout_q,   timeout_d;

    logic branch;
    logic any_hold;

    assign branch   = fe.EX_BranchTaken;
    assign any_hold = fe.HD_HoldPC | fe.HD_Hold_IF_ID | fe.HD_HoldControl;

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        id_ex_ctrl_d  = fe.ID_Ctrl;
        id_ex_valid_d = if_id_valid_q;

        if (branch) begin
            pc_d = fe.EX_BranchTarget;
        end else if (!fe.HD_HoldPC) begin
            pc_d = pc_q + ADDR_W'(FE_PC_INC);
        end

        // A flushed IF/ID keeps its old PC; only the instruction and valid change.
        if (branch) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (!fe.HD_Hold_IF_ID) begin
            if_id_instr_d = fe.IMem_Instr;
            if_id_pc_d    = pc_q;
            if_id_valid_d = 1'b1;
        end

        if (branch || fe.HD_HoldControl) begin
            id_ex_ctrl_d  = '0;
            id_ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = FE_RUN;
        if (branch) begin
            state_d = FE_FLUSH;
        end else if (any_hold) begin
            state_d = FE_STALL;
        end

        // Run length counts cycles spent in STALL and saturates at the limit.
        stall_run_d = '0;
        if (state_d == FE_STALL) begin
            stall_run_d = (stall_run_q == SR_W'(MAX_STALL)) ? stall_run_q
                                                            : stall_run_q + SR_W'(1);
        end

        timeout_d  = timeout_q | (stall_run_d == SR_W'(MAX_STALL));
        mismatch_d = mismatch_q | (!branch && (fe.HD_HoldPC != fe.HD_Hold_IF_ID));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            id_ex_ctrl_q  <= '0;
            id_ex_valid_q <= 1'b0;
            state_q       <= FE_RUN;
            stall_run_q   <= '0;
            mismatch_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            id_ex_ctrl_q  <= id_ex_ctrl_d;
            id_ex_valid_q <= id_ex_valid_d;
            state_q       <= state_d;
            stall_run_q   <= stall_run_d;
            mismatch_q    <= mismatch_d;
            timeout_q     <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fe.HD_HoldControl & ~branch),
        .count (fe.StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (branch),
        .count (fe.FlushCount)
    );

    assign fe.PC           = pc_q;
    assign fe.IF_ID_PC     = if_id_pc_q;
    assign fe.IF_ID_Instr  = if_id_instr_q;
    assign fe.IF_ID_Valid  = if_id_valid_q;
    assign fe.ID_EX_Ctrl   = id_ex_ctrl_q;
    assign fe.ID_EX_Valid  = id_ex_valid_q;
    assign fe.FE_State     = state_q;
    assign fe.HoldMismatch = mismatch_q;
    assign fe.StallTimeout = timeout_q;
endmodule

// File: tb/tb_frontend_stall_ctrl.sv
// Directed-vector bench: each vector pushes its hand-computed post-edge state into
// a queue, and a monitor compares the DUT registers after every rising edge.
module tb_frontend_stall_ctrl;
    import frontend_stall_ctrl_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifi;
        logic        ifv;
        logic [7:0]  ctl;
        logic        idv;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        hm;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    exp_t exp_q[$];

    frontend_stall_ctrl_if #(.ADDR_W(32), .INSTR_W(32), .CTRL_W(8), .CNT_W(16)) bus ();

    frontend_stall_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fe    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int vn, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", name, vn, act, want);
        end
    endtask

    task automatic chk_all(input int vn, input exp_t e);
        chk("PC",           vn, bus.PC,                  e.pc);
        chk("IF_ID_PC",     vn, bus.IF_ID_PC,            e.ifpc);
        chk("IF_ID_Instr",  vn, bus.IF_ID_Instr,         e.ifi);
        chk("IF_ID_Valid",  vn, 32'(bus.IF_ID_Valid),    32'(e.ifv));
        chk("ID_EX_Ctrl",   vn, 32'(bus.ID_EX_Ctrl),     32'(e.ctl));
        chk("ID_EX_Valid",  vn, 32'(bus.ID_EX_Valid),    32'(e.idv));
        chk("FE_State",     vn, 32'(bus.FE_State),       32'(e.st));
        chk("StallCount",   vn, 32'(bus.StallCount),     32'(e.sc));
        chk("FlushCount",   vn, 32'(bus.FlushCount),     32'(e.fc));
        chk("HoldMismatch", vn, 32'(bus.HoldMismatch),   32'(e.hm));
        chk("StallTimeout", vn, 32'(bus.StallTimeout),   32'(e.to));
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ifpc, input logic [31:0] ifi,
                                input logic ifv, input logic [7:0] ctl, input logic idv, input logic [1:0] st,
                                input logic [15:0] sc, input logic [15:0] fc, input logic hm, input logic to);
        exp_t e;
        e.pc = pc; e.ifpc = ifpc; e.ifi = ifi; e.ifv = ifv; e.ctl = ctl; e.idv = idv;
        e.st = st; e.sc = sc; e.fc = fc; e.hm = hm; e.to = to;
        return e;
    endfunction

    // Called at a falling edge: drive inputs, queue the expected state after the
    // coming rising edge, then wait for the next falling edge.
    task automatic vec(input logic [2:0] holds, input logic br, input logic [31:0] tgt,
                       input logic [31:0] imem, input logic [7:0] ctl, input exp_t e);
        bus.HD_HoldPC       = holds[2];
        bus.HD_Hold_IF_ID   = holds[1];
        bus.HD_HoldControl  = holds[0];
        bus.EX_BranchTaken  = br;
        bus.EX_BranchTarget = tgt;
        bus.IMem_Instr      = imem;
        bus.ID_Ctrl         = ctl;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse entirely inside the low clock phase.
    task automatic rst_pulse(input int tag);
        rst_n = 1'b0;
        #1;
        $display("reset pulse %0d: pc=%h ifv=%0d st=%0d sc=%0d hm=%0d to=%0d",
                 tag, bus.PC, bus.IF_ID_Valid, bus.FE_State, bus.StallCount, bus.HoldMismatch, bus.StallTimeout);
        chk_all(-tag, mk(32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, FE_RUN, 16'd0, 16'd0, 1'b0, 1'b0));
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vec_no++;
                $display("vec %0d: pc=%h ifpc=%h ifi=%h ifv=%0d ctl=%h idv=%0d st=%0d sc=%0d fc=%0d hm=%0d to=%0d",
                         vec_no, bus.PC, bus.IF_ID_PC, bus.IF_ID_Instr, bus.IF_ID_Valid, bus.ID_EX_Ctrl,
                         bus.ID_EX_Valid, bus.FE_State, bus.StallCount, bus.FlushCount,
                         bus.HoldMismatch, bus.StallTimeout);
                chk_all(vec_no, e);
            end
        end
    end

    initial begin : stim
        bus.HD_HoldPC = 1'b0; bus.HD_Hold_IF_ID = 1'b0; bus.HD_HoldControl = 1'b0;
        bus.EX_BranchTaken = 1'b0; bus.EX_BranchTarget = '0; bus.IMem_Instr = '0; bus.ID_Ctrl = '0;
        @(negedge clk);
        @(negedge clk);
        rst_pulse(1);

        // Reset release and normal advance
        vec(3'b000, 1'b0, 32'h0, 32'h8C220004, 8'h11, mk(32'h04, 32'h00, 32'h8C220004, 1, 8'h11, 0, FE_RUN, 0, 0, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000A1, 8'h22, mk(32'h08, 32'h04, 32'h000000A1, 1, 8'h22, 1, FE_RUN, 0, 0, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000A2, 8'h33, mk(32'h0C, 32'h08, 32'h000000A2, 1, 8'h33, 1, FE_RUN, 0, 0, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000A3, 8'h44, mk(32'h10, 32'h0C, 32'h000000A3, 1, 8'h44, 1, FE_RUN, 0, 0, 0, 0));
        // Two-cycle load-use stall at PC=0x10, then resume
        vec(3'b111, 1'b0, 32'h0, 32'h000000A4, 8'h55, mk(32'h10, 32'h0C, 32'h000000A3, 1, 8'h00, 0, FE_STALL, 1, 0, 0, 0));
        vec(3'b111, 1'b0, 32'h0, 32'h000000A4, 8'h55, mk(32'h10, 32'h0C, 32'h000000A3, 1, 8'h00, 0, FE_STALL, 2, 0, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000A4, 8'h55, mk(32'h14, 32'h10, 32'h000000A4, 1, 8'h55, 1, FE_RUN, 2, 0, 0, 0));
        // Taken branch to 0x40, then one-cycle FLUSH back to RUN
        vec(3'b000, 1'b1, 32'h40, 32'h000000A5, 8'h66, mk(32'h40, 32'h10, 32'h00000000, 0, 8'h00, 0, FE_FLUSH, 2, 1, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000B0, 8'h77, mk(32'h44, 32'h40, 32'h000000B0, 1, 8'h77, 0, FE_RUN, 2, 1, 0, 0));
        // Branch coincident with all holds: branch wins, StallCount unchanged
        vec(3'b111, 1'b1, 32'h80, 32'h000000B1, 8'h88, mk(32'h80, 32'h40, 32'h00000000, 0, 8'h00, 0, FE_FLUSH, 2, 2, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000C0, 8'h99, mk(32'h84, 32'h80, 32'h000000C0, 1, 8'h99, 0, FE_RUN, 2, 2, 0, 0));
        // HoldPC without Hold_IF_ID sets the sticky mismatch flag
        vec(3'b100, 1'b0, 32'h0, 32'h000000C1, 8'hAA, mk(32'h84, 32'h84, 32'h000000C1, 1, 8'hAA, 1, FE_STALL, 2, 2, 1, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000C1, 8'hBB, mk(32'h88, 32'h84, 32'h000000C1, 1, 8'hBB, 1, FE_RUN, 2, 2, 1, 0));
        rst_pulse(2);

        vec(3'b000, 1'b0, 32'h0, 32'h000000D0, 8'h01, mk(32'h04, 32'h00, 32'h000000D0, 1, 8'h01, 0, FE_RUN, 0, 0, 0, 0));
        // Eight stall cycles: timeout sets on the eighth
        for (int k = 1; k <= 8; k++) begin
            vec(3'b111, 1'b0, 32'h0, 32'h000000D1, 8'h02,
                mk(32'h04, 32'h00, 32'h000000D0, 1, 8'h00, 0, FE_STALL, 16'(k), 0, 0, (k == 8)));
        end
        vec(3'b111, 1'b0, 32'h0, 32'h000000D1, 8'h02, mk(32'h04, 32'h00, 32'h000000D0, 1, 8'h00, 0, FE_STALL, 9, 0, 0, 1));
        rst_pulse(3);

        vec(3'b000, 1'b0, 32'h0, 32'h000000E0, 8'h03, mk(32'h04, 32'h00, 32'h000000E0, 1, 8'h03, 0, FE_RUN, 0, 0, 0, 0));
        // PC wraps modulo 2^32 after a branch to the top of the address space
        vec(3'b000, 1'b1, 32'hFFFFFFFC, 32'h000000E1, 8'h04, mk(32'hFFFFFFFC, 32'h00, 32'h00000000, 0, 8'h00, 0, FE_FLUSH, 0, 1, 0, 0));
        vec(3'b000, 1'b0, 32'h0, 32'h000000E2, 8'h05, mk(32'h00000000, 32'hFFFFFFFC, 32'h000000E2, 1, 8'h05, 0, FE_RUN, 0, 1, 0, 0));

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
